mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with a built-in channel sequencer.
- Generalises the fixed 4-to-1 combinational mux to arbitrary channel count and data width.
- Adds an automatic scan mode that steps through channels after a programmable dwell time.
- Used in the Chapter 5 datapath as the channel-select/sampling front end feeding downstream logic.

Parameters:
N_CH, 4, number of input channels (>=2, need not be a power of two)
DW, 1, data width per channel in bits
DWELL, 500, clock cycles spent on each channel in auto mode (>=1)
SEL_W, $clog2(N_CH), select width; localparam, not overridable

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low freezes all state
mode  input  1  0 = manual select, 1 = auto scan
sel_in  input  SEL_W  manual channel select
din  input  N_CH*DW  packed channel data; channel k occupies din[k*DW +: DW]
dout  output  DW  registered selected data
sel_out  output  SEL_W  channel currently driving dout
valid  output  1  dout holds a live sample
wrap  output  1  one-cycle pulse when auto scan returns from N_CH-1 to 0
sel_err  output  1  one-cycle pulse when manual sel_in >= N_CH

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, sel_out=0, valid=0, wrap=0, sel_err=0, dwell counter=0, state IDLE.
- States:
  - IDLE -> MANUAL when en=1 and mode=0.
  - IDLE -> AUTO when en=1 and mode=1.
  - MANUAL <-> AUTO on a mode change while en=1.
  - Any state -> IDLE when en=0.
- Latency: one cycle. dout(t+1) = din channel sel_out(t+1), sampled at edge t+1. valid=1 in MANUAL and AUTO, 0 in IDLE.
- IDLE: dout and sel_out hold their last values; dwell counter holds; wrap=0.
- MANUAL:
  - sel_out <= sel_in each cycle.
  - If sel_in >= N_CH: sel_out holds, sel_err pulses for 1 cycle, dout keeps sampling the held channel.
- AUTO:
  - Dwell counter counts 0..DWELL-1.
  - On the cycle the counter reaches DWELL-1: counter <= 0 and sel_out <= sel_out+1.
  - From N_CH-1 the next channel is 0, and wrap pulses in the same cycle that sel_out becomes 0.
  - DWELL=1 advances every cycle.
- MANUAL->AUTO: scanning starts from the current sel_out, with the counter cleared to 0.
- AUTO->MANUAL: takes effect on the next edge; the counter is cleared.
- en low mid-dwell: the counter freezes. When en returns and mode is unchanged, it resumes from the frozen count.
- Simultaneous en=0 and mode change: en wins; the state goes to IDLE.
- Width rule: the counter is $clog2(DWELL+1) bits wide and never exceeds DWELL-1.

Optional Feature:
Macro MUX_SCAN_SKIP_EN.
- Defined:
  - Adds input ch_mask[N_CH]. AUTO advances to the next channel whose mask bit is 1, searching upward with wraparound.
  - wrap pulses whenever the selected index numerically decreases.
  - If the mask is all zeros: sel_out holds and valid=0.
  - If the current channel becomes masked mid-dwell: the dwell completes before advancing.
  - MANUAL mode ignores the mask.
- Undefined: the port is absent and every channel is scanned in order.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum typedef (IDLE/MANUAL/AUTO);
  - mode constants MODE_MANUAL=0 and MODE_AUTO=1;
  - a function computing the next-channel index with wrap.
- One sub-module, mux_scan_dwell_cnt: dwell counter with clear, enable and terminal-count outputs.

Test Plan:
- Reset with N_CH=4, DW=8, din={8'h44,8'h33,8'h22,8'h11}; release rst_n, en=1, mode=0, sel_in=2 -> after 1 clk dout=8'h33, sel_out=2, valid=1.
- AUTO with DWELL=3, starting at sel 0 -> sel_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap high only on the cycle sel_out returns to 0.
- N_CH=5, SEL_W=3, manual sel_in=6 -> sel_out holds the previous value, sel_err one-cycle pulse, no X on dout.
- AUTO, DWELL=4, drop en for 5 cycles at count 2 -> valid=0 and sel_out held; on re-enable the channel advances after 1 more cycle.
- Assert rst_n low asynchronously mid-AUTO, between clock edges -> all outputs 0 immediately; after release, no wrap glitch.
- With MUX_SCAN_SKIP_EN, ch_mask=4'b1010, DWELL=1 -> sel_out 1,3,1,3 with wrap on each 3->1 step; ch_mask=0 -> valid=0 and sel_out held.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared types and helpers for the mux_scan_seq channel-select front end.
//   - state_t      : sequencer state (IDLE / MANUAL / AUTO)
//   - MODE_MANUAL / MODE_AUTO : encodings of the mode input
//   - next_ch()    : next channel index in ascending order, wrapping to 0
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Channel after cur in a ring of n_ch channels.
  function automatic int unsigned next_ch(input int unsigned cur, input int unsigned n_ch);
    return (cur + 32'd1 >= n_ch) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt
//   Dwell counter for the auto-scan sequencer. Counts 0..DWELL-1 while inc
//   is high and rolls back to 0 after the terminal count.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  force the count to 0 (has priority over inc)
//   inc   in  advance the count this cycle; count holds when low
//   tc    out count is at DWELL-1 (the next inc completes the dwell)
module mux_scan_dwell_cnt #(
  parameter int DWELL = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  // One spare code of headroom; the count itself never exceeds DWELL-1.
  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq
//   Registered N_CH-channel, DW-bit multiplexer with a channel sequencer.
//   MANUAL mode follows sel_in; AUTO mode steps through the channels after
//   DWELL cycles on each. One cycle of latency: dout always carries the
//   channel that sel_out names in the same cycle.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   en       in  block enable; low freezes all state (state goes IDLE)
//   mode     in  0 = manual select, 1 = auto scan
//   sel_in   in  manual channel select (SEL_W bits)
//   din      in  packed channel data, channel k at din[k*DW +: DW]
//   ch_mask  in  (MUX_SCAN_SKIP_EN only) channels eligible for auto scan
//   dout     out registered selected data
//   sel_out  out channel currently driving dout
//   valid    out dout holds a live sample
//   wrap     out one-cycle pulse when the auto-scan index goes down
//   sel_err  out one-cycle pulse when manual sel_in >= N_CH
// Build option:
//   MUX_SCAN_SKIP_EN - adds ch_mask; auto scan skips masked channels.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int DW    = 1,
  parameter  int DWELL = 500,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [N_CH*DW-1:0] din,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N_CH-1:0]    ch_mask,
`endif
  output logic [DW-1:0]      dout,
  output logic [SEL_W-1:0]   sel_out,
  output logic               valid,
  output logic               wrap,
  output logic               sel_err
);

  // One extra bit so the range check is not a constant when N_CH is 2**SEL_W.
  localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] sel_next;
  logic [SEL_W-1:0] sel_adv;
  logic             has_target;
  logic             valid_next, wrap_next, sel_err_next;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [DW-1:0]    ch_data [N_CH];
  logic [DW-1:0]    dout_sel;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_data[gi] = din[gi*DW +: DW];
  end

  mux_scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

  // Candidate channel for the next auto-scan step.
`ifdef MUX_SCAN_SKIP_EN
  // Walk the ring upward from sel_out; the last probe lands back on sel_out,
  // so a mask holding only the current channel keeps it selected.
  always_comb begin
    logic [SEL_W-1:0] probe;
    sel_adv    = sel_out;
    has_target = 1'b0;
    probe      = sel_out;
    for (int i = 0; i < N_CH; i++) begin
      probe = SEL_W'(next_ch(32'(probe), N_CH));
      if (!has_target && ch_mask[probe]) begin
        has_target = 1'b1;
        sel_adv    = probe;
      end
    end
  end
`else
  assign sel_adv    = SEL_W'(next_ch(32'(sel_out), N_CH));
  assign has_target = 1'b1;
`endif

  // Next state and next registered outputs; everything keys off state_next
  // so the mode seen at an edge takes effect on that same edge.
  always_comb begin
    state_next   = IDLE;
    sel_next     = sel_out;
    valid_next   = 1'b0;
    wrap_next    = 1'b0;
    sel_err_next = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    if (en) begin
      state_next = (mode == MODE_AUTO) ? AUTO : MANUAL;
    end
    case (state_next)
      MANUAL: begin
        valid_next = 1'b1;
        cnt_clr    = 1'b1;
        if ({1'b0, sel_in} >= N_CH_EXT) begin
          sel_err_next = 1'b1;
        end else begin
          sel_next = sel_in;
        end
      end
      AUTO: begin
        valid_next = has_target;
        // The edge coming in from MANUAL only arms the (already cleared)
        // counter, giving the first channel a full dwell. Coming from IDLE
        // the frozen count simply resumes.
        cnt_inc = (state_reg != MANUAL);
        if (cnt_inc && cnt_tc) begin
          sel_next  = sel_adv;
          wrap_next = (sel_adv < sel_out);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dout_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_next == SEL_W'(k)) begin
        dout_sel = ch_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dout      <= '0;
      sel_out   <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_out   <= sel_next;
      valid     <= valid_next;
      wrap      <= wrap_next;
      sel_err   <= sel_err_next;
      if (state_next != IDLE) begin
        dout <= dout_sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq
//   Directed bench for mux_scan_seq. Three instances share clk/rst_n:
//     u0: N_CH=4, DW=8, DWELL=3  (reset, manual, auto scan, async reset)
//     u1: N_CH=5, DW=8, DWELL=4  (out-of-range select, enable drop)
//     u2: N_CH=4, DW=8, DWELL=1  (advance every cycle, channel skip)
//   Define MUX_SCAN_SKIP_EN to build and exercise the channel-skip option.
module tb_mux_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic        en0 = 1'b0, mode0 = 1'b0;
  logic [1:0]  sel0 = 2'd0;
  logic [31:0] din0 = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  dout0;
  logic [1:0]  selo0;
  logic        valid0, wrap0, err0;

  logic        en1 = 1'b0, mode1 = 1'b0;
  logic [2:0]  sel1 = 3'd0;
  logic [39:0] din1 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  dout1;
  logic [2:0]  selo1;
  logic        valid1, wrap1, err1;

  logic        en2 = 1'b0, mode2 = 1'b0;
  logic [1:0]  sel2 = 2'd0;
  logic [7:0]  dout2;
  logic [1:0]  selo2;
  logic        valid2, wrap2, err2;

`ifdef MUX_SCAN_SKIP_EN
  logic [3:0] mask  = 4'b1111;
  logic [4:0] mask1 = 5'b11111;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed reference tables.
  logic [7:0] ch_val   [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [1:0] auto_sel [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  logic [2:0] err_in   [4]  = '{3'd4, 3'd6, 3'd5, 3'd1};
  logic [2:0] err_sel  [4]  = '{3'd4, 3'd4, 3'd4, 3'd1};
  logic       err_exp  [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] err_dout [4]  = '{8'h55, 8'h55, 8'h55, 8'h22};

  mux_scan_seq #(.N_CH(4), .DW(8), .DWELL(3)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .sel_in(sel0), .din(din0),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(mask),
`endif
    .dout(dout0), .sel_out(selo0), .valid(valid0), .wrap(wrap0), .sel_err(err0)
  );

  mux_scan_seq #(.N_CH(5), .DW(8), .DWELL(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel_in(sel1), .din(din1),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(mask1),
`endif
    .dout(dout1), .sel_out(selo1), .valid(valid1), .wrap(wrap1), .sel_err(err1)
  );

  mux_scan_seq #(.N_CH(4), .DW(8), .DWELL(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel_in(sel2), .din(din0),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(mask),
`endif
    .dout(dout2), .sel_out(selo2), .valid(valid2), .wrap(wrap2), .sel_err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({dout0, selo0, valid0, wrap0, err0} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {dout0, selo0, valid0, wrap0, err0});
    end
    rst_n = 1'b1;
    en0 = 1'b1; mode0 = 1'b0; sel0 = 2'd2;
    step();
    n_tests++;
    if (dout0 !== 8'h33 || selo0 !== 2'd2 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_sample: got dout=%h sel=%0d valid=%b want dout=33 sel=2 valid=1",
               dout0, selo0, valid0);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_manual();
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i);
      step();
      n_tests++;
      if (dout0 !== ch_val[i] || selo0 !== 2'(i) || err0 !== 1'b0) begin
        n_fail++;
        $display("FAIL manual_sel%0d: got dout=%h sel=%0d err=%b want dout=%h sel=%0d err=0",
                 i, dout0, selo0, err0, ch_val[i], i);
      end
    end
    $display("[TB] test_manual done");
  endtask

  task automatic test_auto();
    sel0 = 2'd0;
    step();
    mode0 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      n_tests++;
      if (selo0 !== auto_sel[i] || wrap0 !== (i == 12) || dout0 !== ch_val[auto_sel[i]]
          || valid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL auto_step%0d: got sel=%0d wrap=%b dout=%h valid=%b want sel=%0d wrap=%b dout=%h valid=1",
                 i, selo0, wrap0, dout0, valid0, auto_sel[i], (i == 12), ch_val[auto_sel[i]]);
      end
    end
    $display("[TB] test_auto done");
  endtask

  task automatic test_back_to_back();
    step();                         // count now 1 on channel 0
    mode0 = 1'b0; sel0 = 2'd3;
    step();
    n_tests++;
    if (selo0 !== 2'd3 || dout0 !== 8'h44 || wrap0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_to_manual: got sel=%0d dout=%h wrap=%b want sel=3 dout=44 wrap=0",
               selo0, dout0, wrap0);
    end
    mode0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (selo0 !== ((i == 3) ? 2'd0 : 2'd3) || wrap0 !== (i == 3)) begin
        n_fail++;
        $display("FAIL b2b_to_auto%0d: got sel=%0d wrap=%b want sel=%0d wrap=%b",
                 i, selo0, wrap0, (i == 3) ? 0 : 3, (i == 3));
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_sel_err();
    en1 = 1'b1; mode1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel1 = err_in[i];
      step();
      n_tests++;
      if (selo1 !== err_sel[i] || err1 !== err_exp[i] || dout1 !== err_dout[i]) begin
        n_fail++;
        $display("FAIL sel_err_in%0d: got sel=%0d err=%b dout=%h want sel=%0d err=%b dout=%h",
                 err_in[i], selo1, err1, dout1, err_sel[i], err_exp[i], err_dout[i]);
      end
    end
    $display("[TB] test_sel_err done");
  endtask

  task automatic test_en_drop();
    mode1 = 1'b1;
    step();                         // entry from MANUAL, count 0
    step();                         // count 1
    step();                         // count 2
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (valid1 !== 1'b0 || selo1 !== 3'd1 || wrap1 !== 1'b0 || dout1 !== 8'h22) begin
        n_fail++;
        $display("FAIL en_drop_idle%0d: got valid=%b sel=%0d wrap=%b dout=%h want valid=0 sel=1 wrap=0 dout=22",
                 i, valid1, selo1, wrap1, dout1);
      end
    end
    en1 = 1'b1;
    step();
    n_tests++;
    if (valid1 !== 1'b1 || selo1 !== 3'd1) begin
      n_fail++;
      $display("FAIL en_resume_hold: got valid=%b sel=%0d want valid=1 sel=1", valid1, selo1);
    end
    step();
    n_tests++;
    if (selo1 !== 3'd2 || dout1 !== 8'h33) begin
      n_fail++;
      $display("FAIL en_resume_adv: got sel=%0d dout=%h want sel=2 dout=33", selo1, dout1);
    end
    $display("[TB] test_en_drop done");
  endtask

  task automatic test_dwell1();
    logic [1:0] exp_sel [5];
    exp_sel = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    en2 = 1'b1; mode2 = 1'b0; sel2 = 2'd2;
    step();
    mode2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (selo2 !== exp_sel[i] || wrap2 !== (i == 2) || dout2 !== ch_val[exp_sel[i]]) begin
        n_fail++;
        $display("FAIL dwell1_step%0d: got sel=%0d wrap=%b dout=%h want sel=%0d wrap=%b dout=%h",
                 i, selo2, wrap2, dout2, exp_sel[i], (i == 2), ch_val[exp_sel[i]]);
      end
    end
    $display("[TB] test_dwell1 done");
  endtask

`ifdef MUX_SCAN_SKIP_EN
  task automatic test_skip();
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd3, 2'd1, 2'd3, 2'd1};
    mask = 4'b1010;                 // u2 currently on channel 2
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (selo2 !== exp_sel[i] || wrap2 !== (i == 1 || i == 3) || valid2 !== 1'b1) begin
        n_fail++;
        $display("FAIL skip_step%0d: got sel=%0d wrap=%b valid=%b want sel=%0d wrap=%b valid=1",
                 i, selo2, wrap2, valid2, exp_sel[i], (i == 1 || i == 3));
      end
    end
    mask = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (valid2 !== 1'b0 || selo2 !== 2'd1 || wrap2 !== 1'b0) begin
        n_fail++;
        $display("FAIL skip_nomask%0d: got valid=%b sel=%0d wrap=%b want valid=0 sel=1 wrap=0",
                 i, valid2, selo2, wrap2);
      end
    end
    mask = 4'b1111;
    $display("[TB] test_skip done");
  endtask
`endif

  task automatic test_async_reset();
    en0 = 1'b1; mode0 = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;                   // between clock edges
    #1;
    n_tests++;
    if ({dout0, selo0, valid0, wrap0, err0} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", {dout0, selo0, valid0, wrap0, err0});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (selo0 !== ((i == 2) ? 2'd1 : 2'd0) || wrap0 !== 1'b0 || valid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL async_release%0d: got sel=%0d wrap=%b valid=%b want sel=%0d wrap=0 valid=1",
                 i, selo0, wrap0, valid0, (i == 2) ? 1 : 0);
      end
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_back_to_back();
    test_sel_err();
    test_en_drop();
    test_dwell1();
`ifdef MUX_SCAN_SKIP_EN
    test_skip();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
